// File: rtl/uart_rx_jogada.sv
// Receiver for the tic-tac-toe status stream: two UART frames form one 16-bit word.
// Define PARITY_RX_EN for 8E1 frames (even parity); undefined means 8N1.
module uart_rx_jogada #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] estado,
  output logic [3:0] macro,
  output logic [3:0] micro,
  output logic [1:0] resultado_macro,
  output logic [1:0] resultado_jogo,
  output logic       valido,
  output logic       erro_quadro,
  output logic       ocupado
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2);
  localparam int GAP_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_RX_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  state_t           state, state_n;
  logic             rx_p0, rxs, rxs_prev;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       bit_idx;
  logic             byte_idx, byte_idx_n;
  logic [7:0]       sr, hi;
  logic             fall, mid, frame_bad;
  logic             valid_n, err_n, store_hi;
`ifdef PARITY_RX_EN
  logic             par_err;
`endif

  assign fall = rxs_prev & ~rxs;
  assign mid  = (cnt == CNT_MID);
`ifdef PARITY_RX_EN
  assign frame_bad = ~rxs | par_err;
`else
  assign frame_bad = ~rxs;
`endif

  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    store_hi   = 1'b0;
    case (state)
      IDLE:  if (fall) state_n = START;
      START: if (mid) begin
        if (rxs) begin
          err_n      = 1'b1;
          byte_idx_n = 1'b0;
          state_n    = IDLE;
        end else begin
          state_n = DATA;
        end
      end
`ifdef PARITY_RX_EN
      DATA:   if (mid && bit_idx == 3'd7) state_n = PARITY;
      PARITY: if (mid) state_n = STOP;
`else
      DATA:   if (mid && bit_idx == 3'd7) state_n = STOP;
`endif
      STOP: if (mid) begin
        if (frame_bad) begin
          err_n      = 1'b1;
          byte_idx_n = 1'b0;
          state_n    = IDLE;
        end else if (!byte_idx) begin
          store_hi   = 1'b1;
          byte_idx_n = 1'b1;
          state_n    = GAP;
        end else begin
          valid_n    = 1'b1;
          byte_idx_n = 1'b0;
          state_n    = IDLE;
        end
      end
      GAP: begin
        if (fall) begin
          state_n = START;
        end else if (gap_cnt == GAP_MAX) begin
          err_n      = 1'b1;
          byte_idx_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Synchronizer, FSM and control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_p0           <= 1'b1;
      rxs             <= 1'b1;
      rxs_prev        <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      gap_cnt         <= '0;
      bit_idx         <= 3'd0;
      byte_idx        <= 1'b0;
      valido          <= 1'b0;
      erro_quadro     <= 1'b0;
      ocupado         <= 1'b0;
      estado          <= 4'd0;
      macro           <= 4'd0;
      micro           <= 4'd0;
      resultado_macro <= 2'd0;
      resultado_jogo  <= 2'd0;
`ifdef PARITY_RX_EN
      par_err         <= 1'b0;
`endif
    end else begin
      rx_p0       <= rx;
      rxs         <= rx_p0;
      rxs_prev    <= rxs;
      state       <= state_n;
      byte_idx    <= byte_idx_n;
      valido      <= valid_n;
      erro_quadro <= err_n;
      // busy stays up through the valido cycle and drops right after it
      ocupado     <= (state_n != IDLE) | valid_n;
      if (state == IDLE || state == GAP) cnt <= '0;
      else cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (state != DATA) bit_idx <= 3'd0;
      else if (mid) bit_idx <= bit_idx + 3'd1;
`ifdef PARITY_RX_EN
      if (state == PARITY && mid) par_err <= ^{sr, rxs};
`endif
      if (valid_n) begin
        {estado, macro}                                 <= hi;
        {micro, resultado_macro, resultado_jogo}        <= sr;
      end
    end
  end

  // Data-only shift and high-byte holding registers
  always_ff @(posedge clock) begin
    if (state == DATA && mid) sr <= {rxs, sr[7:1]};
    if (store_hi) hi <= sr;
  end

endmodule

// File: tb/tb_uart_rx_jogada.sv
// Scoreboard bench for uart_rx_jogada with CLKS_PER_BIT=8; mirrors PARITY_RX_EN when defined.
module tb_uart_rx_jogada;
  localparam int CPB = 8;
  localparam int TOB = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] estado, macro, micro;
  logic [1:0] resultado_macro, resultado_jogo;
  logic       valido, erro_quadro, ocupado;

  uart_rx_jogada #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .estado(estado), .macro(macro), .micro(micro),
    .resultado_macro(resultado_macro), .resultado_jogo(resultado_jogo),
    .valido(valido), .erro_quadro(erro_quadro), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        is_err;
    logic [15:0] word;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_word = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] fields();
    return {estado, macro, micro, resultado_macro, resultado_jogo};
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef PARITY_RX_EN
    bit_out((^b) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    bit_out(stop_b);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1, 1'b0);
    send_byte(w[7:0], 1'b1, 1'b0);
  endtask

  task automatic expect_word(input logic [15:0] w);
    sbq.push_back({1'b0, w});
    last_word = w;
  endtask

  task automatic expect_err();
    sbq.push_back({1'b1, last_word});
  endtask

  // Monitor: every valido/erro_quadro pulse is matched against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (valido || erro_quadro)) begin
        check("pulse_exclusive", 32'(valido & erro_quadro), 32'd0);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: valido=%0b erro_quadro=%0b, none expected", valido, erro_quadro);
        end else begin
          e = sbq.pop_front();
          check("erro_quadro", 32'(erro_quadro), 32'(e.is_err));
          check("valido", 32'(valido), 32'(!e.is_err));
          check("fields", 32'(fields()), 32'(e.word));
        end
        @(negedge clock);
        check("ocupado_after_pulse", 32'(ocupado), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_fields", 32'(fields()), 32'd0);
    check("reset_valido", 32'(valido), 32'd0);
    check("reset_erro", 32'(erro_quadro), 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;
    idle(4);

    expect_word(16'h5A3C);
    send_word(16'h5A3C);
    idle(2 * CPB);

    expect_err();
    send_byte(8'h5A, 1'b0, 1'b0);
    idle(3 * CPB);
    expect_word(16'hF00F);
    send_word(16'hF00F);
    idle(2 * CPB);

    expect_err();
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    idle(2 * CPB);
    check("glitch_ocupado", 32'(ocupado), 32'd0);

    expect_err();
    send_byte(8'h12, 1'b1, 1'b0);
    idle(TOB * CPB + 4 * CPB);
    check("timeout_ocupado", 32'(ocupado), 32'd0);
    expect_word(16'h1234);
    send_word(16'h1234);
    idle(2 * CPB);

    expect_word(16'h0000);
    expect_word(16'hFFFF);
    expect_word(16'h8001);
    send_word(16'h0000);
    send_word(16'hFFFF);
    send_word(16'h8001);
    idle(2 * CPB);
    check("b2b_last_fields", 32'(fields()), 32'h8001);

    send_byte(8'h77, 1'b1, 1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    check("busy_mid_byte1", 32'(ocupado), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_fields", 32'(fields()), 32'd0);
    check("midreset_ocupado", 32'(ocupado), 32'd0);
    check("midreset_valido", 32'(valido), 32'd0);
    last_word = 16'h0000;
    rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(2 * CPB);
    expect_word(16'hC5A6);
    send_word(16'hC5A6);
    idle(2 * CPB);

`ifdef PARITY_RX_EN
    expect_err();
    send_byte(8'hA5, 1'b1, 1'b1);
    idle(3 * CPB);
    expect_word(16'h3C5A);
    send_word(16'h3C5A);
    idle(2 * CPB);
`endif

    for (int i = 0; i < 8 * CPB && sbq.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
